lpc_postcode_log: RTL and testbench

//  Multi-port LPC POST-code capture with a history FIFO. Snoops I/O writes to NUM_PORTS consecutive

---
 rtl/lpc_postcode_log.sv | 137 +++++++++++++
 tb/tb_lpc_postcode_log.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lpc_postcode_log.sv
// LPC POST-code snooper: latches the latest code per port and logs every accepted write into a
// circular history FIFO. Define POSTCODE_DEDUP_EN to suppress logging of repeated codes per port.
module lpc_postcode_log #(
  parameter int          NUM_PORTS = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0080,
  parameter int          DEPTH     = 16,
  localparam int         PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic                   lclk,
  input  logic                   lreset_n,
  input  logic                   lpc_en,
  input  logic                   device_cs,
  input  logic [15:0]            addr,
  input  logic [7:0]             din,
  input  logic                   io_wren,
  input  logic                   io_rden,
  output logic [7:0]             dout,
  output logic                   dout_oe,
  output logic [8*NUM_PORTS-1:0] postcode,
  input  logic                   log_pop,
  output logic [PW+7:0]          log_data,
  output logic                   log_valid,
  output logic [CW-1:0]          log_count,
  output logic                   log_ovf,
  input  logic                   log_clear
);

  localparam int AW = $clog2(DEPTH);

  // Log handshake: log_valid means log_data holds the oldest entry; asserting log_pop while
  // log_valid is high consumes it at the next lclk edge. A pop with log_valid low is ignored.

  logic [15:0]   offset;
  logic          hit;
  logic [PW-1:0] idx;
  logic [7:0]    cur_code;
  logic          accept;
  logic          dup;
  logic          push;
  logic          pop;
  logic          full;

  logic [7:0]    code_q [NUM_PORTS];
  logic [PW+7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  // Subtraction wraps for addresses below BASE_ADDR, so a single compare covers both bounds.
  assign offset   = addr - BASE_ADDR;
  assign hit      = device_cs && (offset < 16'(NUM_PORTS));
  assign idx      = offset[PW-1:0];
  assign cur_code = code_q[idx];
  assign accept   = hit && io_wren && lpc_en;

  always_comb begin
    dout    = 8'h00;
    dout_oe = 1'b0;
    if (hit && io_rden) begin
      dout    = cur_code;
      dout_oe = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_postcode
    assign postcode[8*g +: 8] = code_q[g];
  end

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) code_q[i] <= 8'h00;
    end else if (accept) begin
      code_q[idx] <= din;
    end
  end

`ifdef POSTCODE_DEDUP_EN
  logic [NUM_PORTS-1:0] seen_q;

  assign dup = seen_q[idx] && (din == cur_code);

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      seen_q <= '0;
    end else if (accept) begin
      seen_q[idx] <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push = accept && !dup;
  assign pop  = log_pop && (count_q != '0);
  assign full = (count_q == CW'(DEPTH));

  always_ff @(posedge lclk) begin
    if (push) mem[wr_ptr_q] <= {idx, din};
  end

  // Clear wins over push/pop; a push into a full log without a pop evicts the oldest entry.
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (log_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (push && pop) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_q + 1'b1;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (full) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        ovf_q    <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end else if (pop) begin
      rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_q - 1'b1;
    end
  end

  assign log_valid = (count_q != '0);
  assign log_count = count_q;
  assign log_ovf   = ovf_q;
  assign log_data  = log_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_lpc_postcode_log.sv
// Directed bench for lpc_postcode_log (NUM_PORTS=2, BASE_ADDR=0x80, DEPTH=16).
module tb_lpc_postcode_log;

  logic        lclk;
  logic        lreset_n;
  logic        lpc_en;
  logic        device_cs;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        io_wren;
  logic        io_rden;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [15:0] postcode;
  logic        log_pop;
  logic [8:0]  log_data;
  logic        log_valid;
  logic [4:0]  log_count;
  logic        log_ovf;
  logic        log_clear;

  int n_checks = 0;
  int n_pass   = 0;

  lpc_postcode_log #(.NUM_PORTS(2), .BASE_ADDR(16'h0080), .DEPTH(16)) dut (
    .lclk(lclk), .lreset_n(lreset_n), .lpc_en(lpc_en), .device_cs(device_cs),
    .addr(addr), .din(din), .io_wren(io_wren), .io_rden(io_rden),
    .dout(dout), .dout_oe(dout_oe), .postcode(postcode),
    .log_pop(log_pop), .log_data(log_data), .log_valid(log_valid),
    .log_count(log_count), .log_ovf(log_ovf), .log_clear(log_clear)
  );

  // Clock / reset
  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    device_cs = 1'b0; addr = 16'h0000; din = 8'h00;
    io_wren = 1'b0; io_rden = 1'b0; log_pop = 1'b0; log_clear = 1'b0;
  endtask

  // One-cycle bus cycle driven between falling edges; state is sampled at the next falling edge.
  task automatic bus_cycle(input logic cs, input logic [15:0] a, input logic [7:0] d,
                           input logic wr, input logic pop, input logic clr);
    @(negedge lclk);
    device_cs = cs; addr = a; din = d; io_wren = wr; log_pop = pop; log_clear = clr;
    @(negedge lclk);
    idle_inputs();
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    bus_cycle(1'b1, a, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    bus_cycle(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_clear();
    bus_cycle(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic io_read(input string tag, input logic [15:0] a,
                         input logic [7:0] exp_d, input logic exp_oe);
    @(negedge lclk);
    device_cs = 1'b1; addr = a; io_rden = 1'b1;
    #1;
    check_eq({tag, "_dout"}, 32'(dout), 32'(exp_d));
    check_eq({tag, "_oe"}, 32'(dout_oe), 32'(exp_oe));
    idle_inputs();
  endtask

  task automatic apply_reset();
    @(negedge lclk);
    lreset_n = 1'b0;
    repeat (2) @(negedge lclk);
    lreset_n = 1'b1;
  endtask

  initial begin
    int exp_n;
    lreset_n = 1'b0;
    lpc_en   = 1'b1;
    idle_inputs();
    repeat (2) @(negedge lclk);
    check_eq("rst_postcode", 32'(postcode), 32'h0);
    check_eq("rst_count", 32'(log_count), 32'd0);
    check_eq("rst_valid", 32'(log_valid), 32'd0);
    check_eq("rst_ovf", 32'(log_ovf), 32'd0);
    check_eq("rst_data", 32'(log_data), 32'h0);
    lreset_n = 1'b1;

    // Basic capture on port 0
    io_write(16'h0080, 8'hA5);
    check_eq("t1_postcode0", 32'(postcode[7:0]), 32'hA5);
    check_eq("t1_count", 32'(log_count), 32'd1);
    check_eq("t1_data", 32'(log_data), 32'h0A5);
    check_eq("t1_valid", 32'(log_valid), 32'd1);

    // Port 1 and read-back, including out-of-range and disabled-capture reads
    io_write(16'h0081, 8'h3C);
    check_eq("t2_postcode1", 32'(postcode[15:8]), 32'h3C);
    io_read("t2_rd81", 16'h0081, 8'h3C, 1'b1);
    io_read("t2_rd82", 16'h0082, 8'h00, 1'b0);
    io_read("t2_rd7f", 16'h007F, 8'h00, 1'b0);
    lpc_en = 1'b0;
    io_read("t2_rd80_dis", 16'h0080, 8'hA5, 1'b1);
    lpc_en = 1'b1;
    check_eq("t2_count", 32'(log_count), 32'd2);
    do_pop();
    check_eq("t2_pop1_data", 32'(log_data), 32'h13C);
    check_eq("t2_pop1_count", 32'(log_count), 32'd1);
    do_pop();
    check_eq("t2_pop2_count", 32'(log_count), 32'd0);
    check_eq("t2_pop2_valid", 32'(log_valid), 32'd0);
    check_eq("t2_pop2_data", 32'(log_data), 32'h0);
    do_pop();
    check_eq("t2_pop_empty", 32'(log_count), 32'd0);

    // Overflow: 17 writes into a 16-deep log
    for (int i = 0; i <= 16; i++) io_write(16'h0080, 8'(i));
    check_eq("t3_count", 32'(log_count), 32'd16);
    check_eq("t3_ovf", 32'(log_ovf), 32'd1);
    check_eq("t3_head", 32'(log_data), 32'h001);
    check_eq("t3_postcode0", 32'(postcode[7:0]), 32'h10);
    do_clear();
    check_eq("t3_clr_count", 32'(log_count), 32'd0);
    check_eq("t3_clr_ovf", 32'(log_ovf), 32'd0);

    // Exactly full, then simultaneous push+pop must not flag overflow
    for (int i = 0; i < 16; i++) io_write(16'h0080, 8'(8'h20 + i));
    check_eq("t4_full_count", 32'(log_count), 32'd16);
    check_eq("t4_full_ovf", 32'(log_ovf), 32'd0);
    check_eq("t4_full_head", 32'(log_data), 32'h020);
    bus_cycle(1'b1, 16'h0081, 8'h77, 1'b1, 1'b1, 1'b0);
    check_eq("t4_pp_count", 32'(log_count), 32'd16);
    check_eq("t4_pp_ovf", 32'(log_ovf), 32'd0);
    check_eq("t4_pp_head", 32'(log_data), 32'h021);
    for (int i = 0; i < 15; i++) do_pop();
    check_eq("t4_last_entry", 32'(log_data), 32'h177);
    do_pop();
    check_eq("t4_drained", 32'(log_count), 32'd0);
    do_pop();
    check_eq("t4_pop_empty_count", 32'(log_count), 32'd0);
    check_eq("t4_pop_empty_valid", 32'(log_valid), 32'd0);

    // Gated writes, and clear racing a push
    lpc_en = 1'b0;
    io_write(16'h0080, 8'h99);
    lpc_en = 1'b1;
    check_eq("t5_dis_postcode", 32'(postcode), 32'h772F);
    check_eq("t5_dis_count", 32'(log_count), 32'd0);
    bus_cycle(1'b0, 16'h0080, 8'h98, 1'b1, 1'b0, 1'b0);
    check_eq("t5_nocs_postcode", 32'(postcode[7:0]), 32'h2F);
    check_eq("t5_nocs_count", 32'(log_count), 32'd0);
    io_write(16'h0080, 8'h44);
    check_eq("t5_pre_clr_count", 32'(log_count), 32'd1);
    bus_cycle(1'b1, 16'h0081, 8'h55, 1'b1, 1'b0, 1'b1);
    check_eq("t5_clr_count", 32'(log_count), 32'd0);
    check_eq("t5_clr_postcode1", 32'(postcode[15:8]), 32'h55);

    // Reset asserted while a write is on the bus loses the write
    @(negedge lclk);
    device_cs = 1'b1; addr = 16'h0080; din = 8'hEE; io_wren = 1'b1;
    #2 lreset_n = 1'b0;
    @(negedge lclk);
    idle_inputs();
    @(negedge lclk);
    lreset_n = 1'b1;
    check_eq("t7_rst_postcode", 32'(postcode), 32'h0);
    check_eq("t7_rst_count", 32'(log_count), 32'd0);

    // Repeated codes: deduplicated only when POSTCODE_DEDUP_EN is defined
    io_write(16'h0080, 8'h00);
    io_write(16'h0080, 8'h00);
`ifdef POSTCODE_DEDUP_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    check_eq("t6_zero_count", 32'(log_count), 32'(exp_n));
    check_eq("t6_zero_head", 32'(log_data), 32'h000);
    io_write(16'h0080, 8'h11);
    io_write(16'h0080, 8'h11);
`ifdef POSTCODE_DEDUP_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    check_eq("t6_dup_count", 32'(log_count), 32'(exp_n));
    check_eq("t6_postcode0", 32'(postcode[7:0]), 32'h11);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
